// File: rtl/delay_sched_pkg.sv
// Shared definitions for the tick-driven delay scheduler: FSM state encoding,
// default sizing, and the helper that extracts one requester's delay field.
package delay_sched_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_CW    = 8;

  // Upper bounds for the slice helper (NREQ <= 8, CW <= 32).
  localparam int MAX_CW    = 32;
  localparam int MAX_VEC_W = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    COUNT = 2'b10,
    DONE  = 2'b11
  } sched_state_e;

  // Return delay field idx of a packed vector whose fields are cw bits wide.
  function automatic logic [MAX_CW-1:0] delay_slice(input logic [MAX_VEC_W-1:0] vec,
                                                    input int idx,
                                                    input int cw);
    logic [MAX_VEC_W-1:0] shifted;
    logic [MAX_CW-1:0]    mask;
    shifted = vec >> (idx * cw);
    mask    = (cw >= MAX_CW) ? '1 : ((MAX_CW'(1) << cw) - MAX_CW'(1));
    return shifted[MAX_CW-1:0] & mask;
  endfunction

endpackage

// File: rtl/delay_scheduler_rr_picker.sv
// Combinational round-robin picker: starting at ptr and wrapping modulo NREQ,
// the first asserted request wins.
module rr_picker
  import delay_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   winner_idx,
  output logic            any_req
);

  // Scan candidates in priority order ptr, ptr+1, ... and keep the first hit.
  always_comb begin
    logic [IW-1:0] cand;
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    cand       = '0;
    winner     = '0;
    winner_idx = '0;
    any_req    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!any_req && req[cand]) begin
        any_req      = 1'b1;
        winner[cand] = 1'b1;
        winner_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/delay_scheduler.sv
// Shares one 100 ms tick-driven delay timer among NREQ requesters. The timer
// is granted round-robin; the owner's delay is latched on grant, counted down
// on each tick, and a one-cycle done pulse is returned on completion.
// Optional build macro DELAY_SCHED_ABORT_EN: when defined, an owner that drops
// its request while counting aborts the delay without a done pulse.
module delay_scheduler
  import delay_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int CW   = DEF_CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             timeout100ms,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*CW-1:0] delay,
  output logic [NREQ-1:0]  grant,
  output logic [NREQ-1:0]  done,
  output logic             busy,
  output logic [CW-1:0]    remaining
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  sched_state_e    state_q, state_d;
  logic [NREQ-1:0] pick_onehot;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [IW-1:0]   owner_idx_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   ptr_adv;
  logic [CW-1:0]   remaining_q;
  logic [CW-1:0]   load_val;
  logic            owner_drop;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
    .req        (req),
    .ptr        (ptr_q),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .any_req    (pick_any)
  );

  assign load_val = CW'(delay_slice(MAX_VEC_W'(delay), int'(owner_idx_q), CW));
  assign ptr_adv  = (owner_idx_q == IW'(NREQ - 1)) ? '0 : owner_idx_q + IW'(1);

`ifdef DELAY_SCHED_ABORT_EN
  assign owner_drop = (state_q == COUNT) && !req[owner_idx_q];
`else
  assign owner_drop = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = LOAD;
      LOAD:    state_d = (load_val == '0) ? DONE : COUNT;
      COUNT: begin
        if (owner_drop)                                    state_d = IDLE;
        else if (timeout100ms && remaining_q == CW'(1))    state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the state being entered.
  always_comb begin
    grant_d = grant_q;
    case (state_d)
      IDLE:    grant_d = '0;
      LOAD:    grant_d = pick_onehot;
      default: grant_d = grant_q;
    endcase
    done_d = (state_d == DONE) ? grant_q : '0;
    busy_d = (state_d != IDLE);
  end

  // Owner index, round-robin pointer and the remaining-tick counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_idx_q <= '0;
      ptr_q       <= '0;
      remaining_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (pick_any) owner_idx_q <= pick_idx;
        LOAD: remaining_q <= load_val;
        COUNT: begin
          if (owner_drop) begin
            remaining_q <= '0;
            ptr_q       <= ptr_adv;
          end else if (timeout100ms && remaining_q != '0) begin
            remaining_q <= remaining_q - CW'(1);
          end
        end
        DONE: ptr_q <= ptr_adv;
        default: ;
      endcase
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_delay_scheduler.sv
// Directed bench for delay_scheduler (NREQ=4, CW=8). Inputs change 1 time unit
// after a rising edge; outputs are sampled at the same point.
module tb_delay_scheduler;

  logic        clk;
  logic        rst;
  logic        timeout100ms;
  logic [3:0]  req;
  logic [31:0] delay;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [7:0]  remaining;

  int passed;
  int failed;
  int onehot_viol;
  int done_count [4];
  int exp_done   [4];
  logic [3:0] exp_g;

  delay_scheduler #(.NREQ(4), .CW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .timeout100ms (timeout100ms),
    .req          (req),
    .delay        (delay),
    .grant        (grant),
    .done         (done),
    .busy         (busy),
    .remaining    (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mid-cycle monitor: one-hot property and per-requester done pulse counts.
  always @(negedge clk) begin
    if ($countones(grant) > 1 || $countones(done) > 1) onehot_viol++;
    for (int i = 0; i < 4; i++) if (done[i]) done_count[i]++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick1();
    timeout100ms = 1'b1;
    @(posedge clk);
    #1;
    timeout100ms = 1'b0;
  endtask

  // n-1 quiet cycles followed by one tick cycle.
  task automatic tick_after(input int n);
    cyc(n - 1);
    tick1();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
  endtask

  initial begin
    passed = 0; failed = 0; onehot_viol = 0;
    for (int i = 0; i < 4; i++) begin done_count[i] = 0; exp_done[i] = 0; end
    rst = 1'b0; timeout100ms = 1'b0; req = '0; delay = '0;
    cyc(3);
    rst = 1'b1;
    cyc(1);

    // Reset state
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_done",  32'(done),  32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_rem",   32'(remaining), 32'h0);

    // Single requester, delay 3, ticks every 10 cycles
    delay = {8'd0, 8'd0, 8'd0, 8'd3};
    req   = 4'b0001;
    cyc(1);
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_busy",  32'(busy),  32'h1);
    cyc(1);
    check("t1_rem3",  32'(remaining), 32'd3);
    tick_after(10);
    check("t1_rem2",  32'(remaining), 32'd2);
    tick_after(10);
    check("t1_rem1",  32'(remaining), 32'd1);
    check("t1_nodone", 32'(done), 32'h0);
    tick_after(10);
    check("t1_done",  32'(done), 32'h1);
    check("t1_rem0",  32'(remaining), 32'd0);
    exp_done[0]++;
    req = '0;
    cyc(1);
    check("t1_idle_grant", 32'(grant), 32'h0);
    check("t1_idle_busy",  32'(busy),  32'h0);
    check("t1_idle_done",  32'(done),  32'h0);

    // All four requesting, delay 1 each: round-robin order 0,1,2,3,0
    do_reset();
    delay = {8'd1, 8'd1, 8'd1, 8'd1};
    req   = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % 4);
      cyc(1);
      check("rr_grant", 32'(grant), 32'(exp_g));
      cyc(1);
      tick1();
      check("rr_done", 32'(done), 32'(exp_g));
      exp_done[i % 4]++;
      if (i == 4) req = '0;
      cyc(1);
      check("rr_idle_grant", 32'(grant), 32'h0);
    end

    // Zero delay: done two cycles after the request, no tick needed
    delay = {8'd0, 8'd0, 8'd0, 8'd0};
    req   = 4'b0100;
    cyc(1);
    check("z_grant", 32'(grant), 32'h4);
    cyc(1);
    check("z_done",  32'(done), 32'h4);
    check("z_busy",  32'(busy), 32'h1);
    exp_done[2]++;
    req = '0;
    cyc(1);
    check("z_busy_low", 32'(busy), 32'h0);
    check("z_grant_low", 32'(grant), 32'h0);

    // Tick during LOAD is not counted
    delay = {8'd2, 8'd0, 8'd0, 8'd0};
    req   = 4'b1000;
    cyc(1);
    check("ld_grant", 32'(grant), 32'h8);
    tick1();
    check("ld_rem2", 32'(remaining), 32'd2);
    tick1();
    check("ld_rem1", 32'(remaining), 32'd1);
    check("ld_nodone", 32'(done), 32'h0);
    tick1();
    check("ld_done", 32'(done), 32'h8);
    exp_done[3]++;
    req = '0;
    cyc(1);

    // Reset while counting with remaining 5
    delay = {8'd0, 8'd0, 8'd0, 8'd5};
    req   = 4'b0001;
    cyc(2);
    check("mr_rem5", 32'(remaining), 32'd5);
    rst = 1'b0;
    #1;
    check("mr_grant", 32'(grant), 32'h0);
    check("mr_done",  32'(done),  32'h0);
    check("mr_busy",  32'(busy),  32'h0);
    check("mr_rem",   32'(remaining), 32'h0);
    req = '0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    tick1();
    tick1();
    cyc(3);
    check("mr_after_busy", 32'(busy), 32'h0);

    // Owner 1 drops its request with remaining 4, requester 3 pending
    do_reset();
    delay = {8'd1, 8'd0, 8'd4, 8'd0};
    req   = 4'b1010;
    cyc(1);
    check("ab_grant1", 32'(grant), 32'h2);
    cyc(1);
    check("ab_rem4", 32'(remaining), 32'd4);
    req = 4'b1000;
    cyc(1);
`ifdef DELAY_SCHED_ABORT_EN
    check("ab_grant_clr", 32'(grant), 32'h0);
    check("ab_busy_clr",  32'(busy),  32'h0);
    check("ab_rem_clr",   32'(remaining), 32'h0);
`else
    check("ab_grant_hold", 32'(grant), 32'h2);
    check("ab_rem_hold",   32'(remaining), 32'd4);
    tick1();
    tick1();
    tick1();
    check("ab_rem1", 32'(remaining), 32'd1);
    tick1();
    check("ab_done1", 32'(done), 32'h2);
    exp_done[1]++;
    cyc(1);
`endif
    cyc(1);
    check("ab_grant3", 32'(grant), 32'h8);
    cyc(1);
    tick1();
    check("ab_done3", 32'(done), 32'h8);
    exp_done[3]++;
    req = '0;
    cyc(2);

    // Whole-run properties
    check("onehot", 32'(onehot_viol), 32'h0);
    for (int i = 0; i < 4; i++) check("done_count", 32'(done_count[i]), 32'(exp_done[i]));

    $display("%0d/%0d checks passed", passed, passed + failed);
    $finish;
  end

endmodule
